// File: rtl/ov7670_cam_emulator_pkg.sv
// Shared definitions for the OV7670 camera emulator: FSM states, test pattern
// codes, default timing and the fixed byte values of the synthetic image.
package ov7670_cam_emulator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_VS   = 3'd1,
    ST_BP   = 3'd2,
    ST_ACT  = 3'd3,
    ST_FP   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PAT_RAMP    = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_SQUARE  = 2'd3
  } pattern_e;

  localparam int DEF_H_ACTIVE = 320;
  localparam int DEF_V_ACTIVE = 240;
  localparam int DEF_H_BLANK  = 144;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 17;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_PCLK_DIV = 2;

  localparam logic [7:0] CHROMA_NEUTRAL = 8'h80;
  localparam logic [7:0] SQ_ON          = 8'hFF;
  localparam logic [7:0] SQ_OFF         = 8'h10;

  // True when |d| < r.
  function automatic logic in_window(int d, int r);
    return (d > -r) && (d < r);
  endfunction

endpackage

// File: rtl/ov7670_cam_emulator_if.sv
// Camera-side pin bundle: run/pattern controls in, OV7670-style pins out.
// master = emulator, slave = capture side.
interface ov7670_cam_emulator_if;
  logic       enable;
  logic [1:0] pattern;
  logic       PCLK;
  logic       Href;
  logic       VSYNC;
  logic [7:0] pixel;
  logic       frame_done;

  modport master (input enable, pattern,
                  output PCLK, Href, VSYNC, pixel, frame_done);
  modport slave  (output enable, pattern,
                  input PCLK, Href, VSYNC, pixel, frame_done);
endinterface

// File: rtl/ov7670_cam_emulator_pattern.sv
// Test image byte generator: turns latched pattern, pixel x, line y and byte
// parity into the next YUV422 byte (Y on even bytes, neutral chroma on odd).
// With CAM_EMU_SCROLL_EN the x coordinate is offset by the frame counter.
module ov7670_cam_emulator_pattern
  import ov7670_cam_emulator_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int XW       = 9,
  parameter int YW       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick_i,
  input  logic          href_i,
  input  pattern_e      pattern_i,
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  input  logic          odd_i,
`ifdef CAM_EMU_SCROLL_EN
  input  logic [7:0]    frame_cnt_i,
`endif
  output logic [7:0]    pixel_o
);

  logic [15:0] xs, ys;
  int          dx, dy;
  logic [7:0]  luma, byte_d;

  // Pattern lookup for the byte about to be presented.
  always_comb begin
`ifdef CAM_EMU_SCROLL_EN
    xs = 16'(x_i) + 16'(frame_cnt_i);
`else
    xs = 16'(x_i);
`endif
    ys   = 16'(y_i);
    dx   = int'(xs) - H_ACTIVE / 2;
    dy   = int'(ys) - V_ACTIVE / 2;
    luma = 8'h00;
    case (pattern_i)
      PAT_RAMP:    luma = xs[7:0];
      PAT_BARS:    luma = xs[5] ? 8'hFF : 8'h00;
      PAT_CHECKER: luma = (xs[3] ^ ys[3]) ? 8'hFF : 8'h00;
      default:     luma = (in_window(dx, 4) && in_window(dy, 4)) ? SQ_ON : SQ_OFF;
    endcase
    byte_d = odd_i ? CHROMA_NEUTRAL : luma;
  end

  // Data register: only moves on the PCLK falling tick, forced to 0 outside Href.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pixel_o <= 8'h00;
    else if (tick_i) pixel_o <= href_i ? byte_d : 8'h00;
  end

endmodule

// File: rtl/ov7670_cam_emulator.sv
// Synthetic OV7670 source: PCLK divider, byte/line counters and frame FSM.
// All state moves on the clk cycle that drives PCLK 1->0, so data is stable
// at PCLK rising edges. Optional macro CAM_EMU_SCROLL_EN adds a frame counter
// that scrolls the image horizontally by one pixel per frame.
module ov7670_cam_emulator
  import ov7670_cam_emulator_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int H_BLANK  = DEF_H_BLANK,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_FP     = DEF_V_FP,
  parameter int PCLK_DIV = DEF_PCLK_DIV
) (
  input logic                   clk,
  input logic                   rst_n,
  ov7670_cam_emulator_if.master cam
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int BW       = $clog2(LINE_LEN);
  localparam int V_MAX01  = (V_SYNC > V_BP) ? V_SYNC : V_BP;
  localparam int V_MAX23  = (V_ACTIVE > V_FP) ? V_ACTIVE : V_FP;
  localparam int V_MAX    = (V_MAX01 > V_MAX23) ? V_MAX01 : V_MAX23;
  localparam int LW       = $clog2(V_MAX + 1);
  localparam int DW       = $clog2(PCLK_DIV + 1);

  localparam logic [BW-1:0] BYTE_LAST = BW'(LINE_LEN - 1);
  localparam logic [BW-1:0] ACT_BYTES = BW'(2 * H_ACTIVE);
  localparam logic [LW-1:0] VS_LAST   = LW'(V_SYNC - 1);
  localparam logic [LW-1:0] BP_LAST   = LW'(V_BP - 1);
  localparam logic [LW-1:0] ACT_LAST  = LW'(V_ACTIVE - 1);
  localparam logic [LW-1:0] FP_LAST   = LW'(V_FP - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(PCLK_DIV - 1);

  logic [DW-1:0] div_q;
  logic          pclk_q, tick;
  state_e        state_q, state_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [LW-1:0] line_q, line_d;
  pattern_e      pat_q, pat_d;
  logic          href_q, href_d, vsync_q, fdone_q, fdone_d, line_end;
  logic [7:0]    pixel_q;

  // PCLK divider: toggles every PCLK_DIV clks, free-running out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      pclk_q <= 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_q  <= '0;
      pclk_q <= ~pclk_q;
    end else begin
      div_q  <= div_q + DW'(1);
    end
  end

  assign tick     = pclk_q && (div_q == DIV_LAST);
  assign line_end = (byte_q == BYTE_LAST);
  assign href_d   = (state_d == ST_ACT) && (byte_d < ACT_BYTES);

  // Next-state for counters and FSM; only a tick moves anything.
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    line_d  = line_q;
    pat_d   = pat_q;
    fdone_d = 1'b0;
    if (tick) begin
      byte_d = line_end ? '0 : byte_q + BW'(1);
      case (state_q)
        ST_IDLE: begin
          byte_d = '0;
          line_d = '0;
          if (cam.enable) begin
            state_d = ST_VS;
            pat_d   = pattern_e'(cam.pattern);
          end
        end
        ST_VS: if (line_end) begin
          if (line_q == VS_LAST) begin state_d = ST_BP; line_d = '0; end
          else line_d = line_q + LW'(1);
        end
        ST_BP: if (line_end) begin
          if (line_q == BP_LAST) begin state_d = ST_ACT; line_d = '0; end
          else line_d = line_q + LW'(1);
        end
        ST_ACT: if (line_end) begin
          if (line_q == ACT_LAST) begin state_d = ST_FP; line_d = '0; end
          else line_d = line_q + LW'(1);
        end
        ST_FP: if (line_end) begin
          if (line_q == FP_LAST) begin
            fdone_d = 1'b1;
            line_d  = '0;
            // enable is only looked at here, so a frame is never cut short.
            if (cam.enable) begin
              state_d = ST_VS;
              pat_d   = pattern_e'(cam.pattern);
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            line_d = line_q + LW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, counters and registered sync outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      byte_q  <= '0;
      line_q  <= '0;
      pat_q   <= PAT_RAMP;
      href_q  <= 1'b0;
      vsync_q <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      line_q  <= line_d;
      pat_q   <= pat_d;
      fdone_q <= fdone_d;
      if (tick) begin
        href_q  <= href_d;
        vsync_q <= (state_d == ST_VS);
      end
    end
  end

`ifdef CAM_EMU_SCROLL_EN
  logic [7:0] frame_cnt_q;

  // Frame counter driving the horizontal scroll.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       frame_cnt_q <= 8'd0;
    else if (fdone_d) frame_cnt_q <= frame_cnt_q + 8'd1;
  end
`endif

  ov7670_cam_emulator_pattern #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .XW       (BW - 1),
    .YW       (LW)
  ) u_pattern (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_i      (tick),
    .href_i      (href_d),
    .pattern_i   (pat_q),
    .x_i         (byte_d[BW-1:1]),
    .y_i         (line_d),
    .odd_i       (byte_d[0]),
`ifdef CAM_EMU_SCROLL_EN
    .frame_cnt_i (frame_cnt_q),
`endif
    .pixel_o     (pixel_q)
  );

  assign cam.PCLK       = pclk_q;
  assign cam.Href       = href_q;
  assign cam.VSYNC      = vsync_q;
  assign cam.pixel      = pixel_q;
  assign cam.frame_done = fdone_q;

endmodule
